xorwow_prng_mc: RTL and testbench
=================================

Name: xorwow_prng_mc

Overview:
Multi-channel, parametrised successor to the single-channel xorwow generator. NUM_CH independent xorwow engines share one Weyl counter. Seeds are written through a shadow-register port and committed atomically. Samples for all channels are emitted together as one wide word on a valid/ready stream, with back-pressure and an orderly stop. The block feeds Monte-Carlo and noise-injection datapaths in the PRNG subsystem.

Parameters:
NUM_CH, 4, number of parallel xorwow engines (1..16)
WEYL_INC, 32'd362437, Weyl counter increment per step
WEYL_INIT, 32'd0, Weyl counter value loaded on commit

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; begin generation
stop  input  1  pulse; end generation
seed_we  input  1  write seed_data to shadow seed register
seed_ch  input  CH_W  target channel; CH_W = max(1, clog2(NUM_CH))
seed_idx  input  3  state word v0..v4; values 5..7 ignored
seed_data  input  32  seed word
seed_commit  input  1  pulse; copy all shadow seeds to working state
busy  output  1  high in LOAD, RUN and DRAIN
out_valid  output  1  out_data holds an unconsumed sample set
out_ready  input  1  consumer accepts out_data
out_data  output  32*NUM_CH  channel k sample in bits [32k+31:32k]

Behaviour:
- Reset (async, rst=1): FSM=IDLE; all shadow and working words=0; Weyl d=0; seeded=0; out_valid=0; out_data=0; busy=0.
- Shadow write: seed_we=1 with seed_idx<=4 and seed_ch<NUM_CH writes shadow[seed_ch][seed_idx] at the next edge. Out-of-range writes are dropped. Writes are legal in any state and never disturb the working state.
- Step per channel, 32-bit arithmetic, shifts logical, overflow wraps:
  - t = v0; t ^= t>>2; t ^= t<<1
  - n = t ^ v4 ^ (v4<<4)
  - v0..v3 <= v1..v4; v4 <= n
  - Shared counter: d <= d + WEYL_INC
  - Sample = n + (d + WEYL_INC), i.e. the new n plus the updated d.
- Zero-seed guard: if a channel's five shadow words are all 0 at commit, its working state loads 123456789, 362436069, 521288629, 88675123, 5783321 into v0..v4.
- FSM states:
  - IDLE: seed_commit -> LOAD. start -> RUN only if seeded=1; otherwise start is ignored.
  - LOAD (1 cycle): working <= shadow (with zero-seed guard); d <= WEYL_INIT; seeded <= 1; out_valid <= 0 (any pending sample is discarded). Next state is RUN if start was seen in the commit cycle or the FSM came from RUN; otherwise IDLE.
  - RUN: when out_valid=0 or out_ready=1, all channels step. out_data is registered with the new samples and out_valid=1 on the next cycle.
    - Sustained throughput: 1 sample set per cycle while out_ready=1.
    - Latency: 1 cycle from entering RUN to the first valid.
    - out_valid=1 with out_ready=0: out_data and all state are held stable.
    - stop: if out_valid=0, or out_ready=1 in the same cycle -> IDLE with out_valid=0. Otherwise -> DRAIN.
    - seed_commit -> LOAD.
  - DRAIN: no stepping. When out_ready=1, out_valid <= 0 and the FSM goes to IDLE. seed_commit -> LOAD, then IDLE.
- Simultaneous events:
  - stop beats start.
  - seed_commit beats start and stop, except that the start/RUN return rule of LOAD still applies.
  - start while in RUN has no effect.
- The working state survives IDLE, so a later start resumes the same sequence.
- rst asserted mid-operation clears everything immediately, with no drain.

Optional Feature:
XORWOW_SAMPLE_CNT_EN
- Defined: adds output sample_cnt [47:0], the count of accepted sample sets (out_valid & out_ready). It wraps at 2^48, is cleared in LOAD and reset to 0.
- Undefined: the port and counter are absent; everything else is unchanged.

Test Plan:
- NUM_CH=2. Ch0 seed v0=1, v1..v4=0; commit; start; out_ready=1. Ch0 samples are 362440, 724925, 1088082 on consecutive cycles.
- Ch0 all shadow words 0; ch1 explicit 123456789, 362436069, 521288629, 88675123, 5783321; commit+start. Ch0 and ch1 samples are identical for 100 sets.
- Back-pressure: out_ready low for 5 cycles mid-stream. out_data stays constant and no sets are skipped; the sequence after release equals the unstalled reference.
- stop while out_valid=1 and out_ready=0: FSM enters DRAIN with busy=1. After out_ready=1, the set is consumed once, then out_valid=0 and busy=0. A later start resumes the sequence with the next value (for example, 724925 following 362440).
- start with seeded=0: no valid ever appears. seed_idx=6 or seed_ch=3 (with NUM_CH=2) writes leave the shadow state unchanged. Commit mid-RUN: the pending sample is dropped and the sequence restarts at 362440.
- Async rst pulse between clock edges during RUN: out_valid=0, out_data=0 and busy=0 immediately. start after reset is ignored until a new commit.

Source files
------------

// File: rtl/xorwow_prng_mc.sv
// Multi-channel xorwow PRNG: NUM_CH engines, shared Weyl counter, shadow seeds, valid/ready output.
// Optional sample_cnt output when XORWOW_SAMPLE_CNT_EN is defined.
module xorwow_prng_mc #(
    parameter int unsigned NUM_CH    = 4,
    parameter logic [31:0] WEYL_INC  = 32'd362437,
    parameter logic [31:0] WEYL_INIT = 32'd0,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   seed_we,
    input  logic [CH_W-1:0]        seed_ch,
    input  logic [2:0]             seed_idx,
    input  logic [31:0]            seed_data,
    input  logic                   seed_commit,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [32*NUM_CH-1:0]   out_data
`ifdef XORWOW_SAMPLE_CNT_EN
    ,
    output logic [47:0]            sample_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t         r_state;
    logic           r_seeded;
    logic           r_load_run;
    logic [31:0]    r_d;
    logic [31:0]    r_shadow [NUM_CH][5];
    logic [31:0]    r_work   [NUM_CH][5];

    logic [31:0]          w_d_next;
    logic [31:0]          w_n [NUM_CH];
    logic [32*NUM_CH-1:0] w_samples;
    logic [NUM_CH-1:0]    w_zero;
    logic                 w_can_step;

    function automatic logic [31:0] f_guard(input int unsigned idx);
        case (idx)
            0:       f_guard = 32'd123456789;
            1:       f_guard = 32'd362436069;
            2:       f_guard = 32'd521288629;
            3:       f_guard = 32'd88675123;
            default: f_guard = 32'd5783321;
        endcase
    endfunction

    function automatic logic [31:0] f_next(input logic [31:0] v0, input logic [31:0] v4);
        logic [31:0] t;
        t = v0;
        t = t ^ (t >> 2);
        t = t ^ (t << 1);
        f_next = t ^ v4 ^ (v4 << 4);
    endfunction

    // Candidate next word and sample per channel, plus zero-seed detection
    always_comb begin
        w_d_next  = r_d + WEYL_INC;
        w_samples = '0;
        w_zero    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_n[k] = f_next(r_work[k][0], r_work[k][4]);
            w_samples[32*k +: 32] = w_n[k] + w_d_next;
            w_zero[k] = ((r_shadow[k][0] | r_shadow[k][1] | r_shadow[k][2] |
                          r_shadow[k][3] | r_shadow[k][4]) == 32'd0);
        end
    end

    assign w_can_step = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_seeded   <= 1'b0;
            r_load_run <= 1'b0;
            r_d        <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                for (int unsigned i = 0; i < 5; i++) begin
                    r_shadow[k][i] <= '0;
                    r_work[k][i]   <= '0;
                end
            end
        end else begin
            // Channel loop bounds drop out-of-range seed_ch/seed_idx writes
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                for (int unsigned i = 0; i < 5; i++) begin
                    if (seed_we && seed_ch == CH_W'(k) && seed_idx == 3'(i))
                        r_shadow[k][i] <= seed_data;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (seed_commit) begin
                        r_state    <= S_LOAD;
                        r_load_run <= start;
                        busy       <= 1'b1;
                    end else if (start && !stop && r_seeded) begin
                        r_state <= S_RUN;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        for (int unsigned i = 0; i < 5; i++) begin
                            r_work[k][i] <= w_zero[k] ? f_guard(i) : r_shadow[k][i];
                        end
                    end
                    r_d       <= WEYL_INIT;
                    r_seeded  <= 1'b1;
                    out_valid <= 1'b0;
                    r_state   <= r_load_run ? S_RUN : S_IDLE;
                    busy      <= r_load_run;
                end
                S_RUN: begin
                    if (seed_commit) begin
                        r_state    <= S_LOAD;
                        r_load_run <= 1'b1;
                    end else if (stop) begin
                        if (w_can_step) begin
                            r_state   <= S_IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (w_can_step) begin
                        for (int unsigned k = 0; k < NUM_CH; k++) begin
                            for (int unsigned i = 0; i < 4; i++) begin
                                r_work[k][i] <= r_work[k][i+1];
                            end
                            r_work[k][4] <= w_n[k];
                        end
                        r_d       <= w_d_next;
                        out_data  <= w_samples;
                        out_valid <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (seed_commit) begin
                        r_state    <= S_LOAD;
                        r_load_run <= 1'b0;
                    end else if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef XORWOW_SAMPLE_CNT_EN
    // Accepted sample-set counter, restarted on every commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sample_cnt <= '0;
        else if (r_state == S_LOAD)
            sample_cnt <= '0;
        else if (out_valid && out_ready)
            sample_cnt <= sample_cnt + 48'd1;
    end
`else
    // Sample counter not built in this configuration
`endif

endmodule

// File: tb/tb_xorwow_prng_mc.sv
// Self-checking bench for xorwow_prng_mc with a behavioural sequence model and random stimulus.
module tb_xorwow_prng_mc;

    localparam int unsigned NCH = 3;
    localparam int unsigned CHW = 2;
    localparam logic [31:0] INC = 32'd362437;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic                 seed_we = 1'b0;
    logic [CHW-1:0]       seed_ch = '0;
    logic [2:0]           seed_idx = '0;
    logic [31:0]          seed_data = '0;
    logic                 seed_commit = 1'b0;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [32*NCH-1:0]    out_data;
`ifdef XORWOW_SAMPLE_CNT_EN
    logic [47:0]          sample_cnt;
`endif

    xorwow_prng_mc #(.NUM_CH(NCH), .WEYL_INC(INC), .WEYL_INIT(32'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .seed_we(seed_we), .seed_ch(seed_ch), .seed_idx(seed_idx),
        .seed_data(seed_data), .seed_commit(seed_commit),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
`ifdef XORWOW_SAMPLE_CNT_EN
        , .sample_cnt(sample_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: shadow seeds, working words and Weyl counter
    logic [31:0] ms [NCH][5];
    logic [31:0] mv [NCH][5];
    logic [31:0] md;

    task automatic m_clear();
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 5; i++) begin
                ms[c][i] = '0;
                mv[c][i] = '0;
            end
        md = '0;
    endtask

    task automatic m_commit();
        logic [31:0] g [5];
        bit allz;
        g[0] = 32'd123456789; g[1] = 32'd362436069; g[2] = 32'd521288629;
        g[3] = 32'd88675123;  g[4] = 32'd5783321;
        for (int c = 0; c < NCH; c++) begin
            allz = 1'b1;
            for (int i = 0; i < 5; i++) if (ms[c][i] != 0) allz = 1'b0;
            for (int i = 0; i < 5; i++) mv[c][i] = allz ? g[i] : ms[c][i];
        end
        md = 32'd0;
    endtask

    function automatic logic [31:0] m_word(input int c);
        logic [31:0] t;
        t = mv[c][0];
        t = t ^ (t >> 2);
        t = t ^ (t << 1);
        return t ^ mv[c][4] ^ (mv[c][4] << 4);
    endfunction

    function automatic logic [32*NCH-1:0] m_peek();
        logic [32*NCH-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[32*c +: 32] = m_word(c) + (md + INC);
        return r;
    endfunction

    task automatic m_adv();
        logic [31:0] n;
        for (int c = 0; c < NCH; c++) begin
            n = m_word(c);
            for (int i = 0; i < 4; i++) mv[c][i] = mv[c][i+1];
            mv[c][4] = n;
        end
        md = md + INC;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int idx, input logic [31:0] data);
        seed_we = 1'b1;
        seed_ch = CHW'(ch);
        seed_idx = 3'(idx);
        seed_data = data;
        tick();
        seed_we = 1'b0;
        if (idx <= 4 && ch < NCH) ms[ch][idx] = data;
    endtask

    // Commit cycle plus the LOAD cycle, consumer stalled throughout
    task automatic commit(input logic with_start);
        out_ready = 1'b0;
        seed_commit = 1'b1;
        start = with_start;
        tick();
        seed_commit = 1'b0;
        start = 1'b0;
        m_commit();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL reset: busy=%b valid=%b data=%h, required 0/0/0", busy, out_valid, out_data);
        else n_pass++;
        rst = 1'b0;
        m_clear();
        tick();
    endtask

    task automatic test_unseeded_start();
        bit seen;
        seen = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) begin
            if (out_valid || busy) seen = 1'b1;
            tick();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL unseeded_start: activity seen=%b, required 0", seen);
        else n_pass++;
    endtask

    task automatic test_known_vector();
        logic [31:0] kv [3];
        int w;
        kv[0] = 32'd362440; kv[1] = 32'd724925; kv[2] = 32'd1088082;
        wr(0, 0, 32'd1);
        commit(1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = 0;
            while (!out_valid && w < 8) begin tick(); w++; end
            n_total++;
            if (!out_valid) $display("FAIL known_vector[%0d]: timeout, valid=0 required 1", i);
            else if (out_data[31:0] !== kv[i] || out_data !== m_peek())
                $display("FAIL known_vector[%0d]: got %0d (%h) required %0d (%h)", i, out_data[31:0], out_data, kv[i], m_peek());
            else n_pass++;
            m_adv();
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_commit_mid_run();
        logic [31:0] kv [2];
        int w;
        kv[0] = 32'd362440; kv[1] = 32'd724925;
        n_total++;
        if (out_valid !== 1'b1 || out_data !== m_peek())
            $display("FAIL stalled_pending: valid=%b data=%h required 1/%h", out_valid, out_data, m_peek());
        else n_pass++;
        commit(1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w = 0;
            while (!out_valid && w < 8) begin tick(); w++; end
            n_total++;
            if (!out_valid) $display("FAIL commit_mid_run[%0d]: timeout, valid=0 required 1", i);
            else if (out_data[31:0] !== kv[i] || out_data !== m_peek())
                $display("FAIL commit_mid_run[%0d]: got %0d required %0d", i, out_data[31:0], kv[i]);
            else n_pass++;
            m_adv();
            tick();
        end
    endtask

    task automatic test_drain();
        int w;
        commit(1'b1);
        w = 0;
        while (!out_valid && w < 8) begin tick(); w++; end
        n_total++;
        if (!out_valid || out_data[31:0] !== 32'd362440 || out_data !== m_peek())
            $display("FAIL drain_first: valid=%b got %0d required 362440", out_valid, out_data[31:0]);
        else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        n_total++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== m_peek())
            $display("FAIL drain_hold: busy=%b valid=%b data=%h required 1/1/%h", busy, out_valid, out_data, m_peek());
        else n_pass++;
        out_ready = 1'b1;
        tick();
        m_adv();
        repeat (3) begin
            n_total++;
            if (busy !== 1'b0 || out_valid !== 1'b0)
                $display("FAIL drain_done: busy=%b valid=%b required 0/0", busy, out_valid);
            else n_pass++;
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (!out_valid && w < 8) begin tick(); w++; end
        n_total++;
        if (!out_valid || out_data[31:0] !== 32'd724925 || out_data !== m_peek())
            $display("FAIL drain_resume: valid=%b got %0d required 724925", out_valid, out_data[31:0]);
        else n_pass++;
        m_adv();
        tick();
    endtask

    task automatic test_zero_guard();
        int w;
        logic [31:0] g [5];
        g[0] = 32'd123456789; g[1] = 32'd362436069; g[2] = 32'd521288629;
        g[3] = 32'd88675123;  g[4] = 32'd5783321;
        for (int i = 0; i < 5; i++) wr(0, i, 32'd0);
        for (int i = 0; i < 5; i++) wr(1, i, g[i]);
        commit(1'b1);
        out_ready = 1'b1;
        for (int s = 0; s < 100; s++) begin
            w = 0;
            while (!out_valid && w < 8) begin tick(); w++; end
            n_total++;
            if (!out_valid) $display("FAIL zero_guard[%0d]: timeout", s);
            else if (out_data !== m_peek() || out_data[31:0] !== out_data[63:32])
                $display("FAIL zero_guard[%0d]: got %h required %h", s, out_data, m_peek());
            else n_pass++;
            m_adv();
            tick();
        end
    endtask

    task automatic test_invalid_writes();
        int w;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        m_adv();
        wr(0, 5, $urandom);
        wr(0, 6, $urandom);
        wr(1, 7, $urandom);
        wr(3, 0, $urandom);
        wr(3, 4, $urandom);
        wr(2, 2, $urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            w = 0;
            while (!out_valid && w < 8) begin tick(); w++; end
            n_total++;
            if (!out_valid || out_data !== m_peek())
                $display("FAIL resume_after_writes[%0d]: got %h required %h", s, out_data, m_peek());
            else n_pass++;
            m_adv();
            tick();
        end
        commit(1'b1);
        out_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            w = 0;
            while (!out_valid && w < 8) begin tick(); w++; end
            n_total++;
            if (!out_valid || out_data !== m_peek())
                $display("FAIL dropped_writes[%0d]: got %h required %h", s, out_data, m_peek());
            else n_pass++;
            m_adv();
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int consumed;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 5; i++) wr(c, i, $urandom);
        commit(1'b1);
        consumed = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (cyc >= 30 && cyc < 35) out_ready = 1'b0;
            else if (cyc < 10) out_ready = 1'b1;
            else out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid) begin
                n_total++;
                if (out_data !== m_peek())
                    $display("FAIL stream[cyc %0d]: got %h required %h", cyc, out_data, m_peek());
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                m_adv();
                consumed++;
            end
            tick();
        end
        n_total++;
        if (consumed < 40) $display("FAIL stream_throughput: consumed %0d required at least 40", consumed);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit seen;
        out_ready = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0)
            $display("FAIL async_reset: valid=%b data=%h busy=%b required 0/0/0", out_valid, out_data, busy);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            if (out_valid || busy) seen = 1'b1;
            tick();
        end
        n_total++;
        if (seen !== 1'b0) $display("FAIL start_after_reset: activity seen=%b, required 0", seen);
        else n_pass++;
    endtask

    initial begin
        m_clear();
        test_reset();
        test_unseeded_start();
        test_known_vector();
        test_commit_mid_run();
        test_drain();
        test_zero_guard();
        test_invalid_writes();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
